// File: rtl/pool_ctrl_if.sv
// rtl/pool_ctrl_if.sv - sequencer/DRAM bus bundle for the max-pooling controller
interface pool_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
);
    // Sequencer start/geometry and completion status
    logic                  enable;
    logic [4:0]            num_chnls;
    logic [5:0]            map_height;
    logic [5:0]            map_width;
    logic                  busy;
    logic                  done;

    // Shared DRAM port: read data returns the cycle after the read address
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  dram_en_rd;
    logic                  dram_en_wr;

    // Sequencer + DRAM side
    modport master (
        output enable, num_chnls, map_height, map_width, data_in,
        input  addr_in, addr_out, data_out, dram_en_rd, dram_en_wr, busy, done
    );

    // Pooling controller side
    modport slave (
        input  enable, num_chnls, map_height, map_width, data_in,
        output addr_in, addr_out, data_out, dram_en_rd, dram_en_wr, busy, done
    );
endinterface

// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - 2x2 stride-2 signed max-pooling controller and datapath
module pool_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] IFMAP_BASE = 18'd131072,
    parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'd196608
) (
    input  logic       clk,
    input  logic       srstn,
    pool_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_LAST,
        S_WR,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic [4:0]                   r_chnls;
    logic [4:0]                   r_oh;
    logic [4:0]                   r_ow;
    logic [3:0]                   r_c;
    logic [3:0]                   r_py;
    logic [3:0]                   r_px;
    logic signed [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]        r_data_out;

    logic                         w_rd;
    logic                         w_wr;
    logic                         w_dx;
    logic                         w_dy;
    logic [ADDR_WIDTH-1:0]        w_rd_addr;
    logic [ADDR_WIDTH-1:0]        w_wr_addr;
    logic signed [DATA_WIDTH-1:0] w_din;
    logic signed [DATA_WIDTH-1:0] w_max;
    logic [4:0]                   w_oh_in;
    logic [4:0]                   w_ow_in;
    logic                         w_empty;
    logic                         w_px_last;
    logic                         w_py_last;
    logic                         w_c_last;

    // Window offset of the read issued in each read state: RD1/RD3 take the
    // right column, RD2/RD3 the lower row.
    assign w_dx = (r_state == S_RD1) || (r_state == S_RD3);
    assign w_dy = (r_state == S_RD2) || (r_state == S_RD3);
    assign w_rd = (r_state == S_RD0) || (r_state == S_RD1) ||
                  (r_state == S_RD2) || (r_state == S_RD3);
    assign w_wr = (r_state == S_WR);

    // y = 2*py+dy and x = 2*px+dx are plain bit concatenations in 5-bit fields
    assign w_rd_addr = IFMAP_BASE + ADDR_WIDTH'({r_c, r_py, w_dy, r_px, w_dx});
    assign w_wr_addr = OFMAP_BASE + ADDR_WIDTH'({r_c, 1'b0, r_py, 1'b0, r_px});

    assign w_din = bus.data_in;
    assign w_max = (w_din > r_acc) ? w_din : r_acc;

    // Pooled dims from the live ports, only used at the start decision
    assign w_oh_in = 5'(bus.map_height >> 1);
    assign w_ow_in = 5'(bus.map_width >> 1);
    assign w_empty = (bus.num_chnls == 5'd0) || (w_oh_in == 5'd0) || (w_ow_in == 5'd0);

    assign w_px_last = ({1'b0, r_px} == r_ow - 5'd1);
    assign w_py_last = ({1'b0, r_py} == r_oh - 5'd1);
    assign w_c_last  = ({1'b0, r_c} == r_chnls - 5'd1);

    assign bus.dram_en_rd = w_rd;
    assign bus.dram_en_wr = w_wr;
    assign bus.addr_in    = w_rd ? w_rd_addr : '0;
    assign bus.addr_out   = w_wr ? w_wr_addr : '0;
    assign bus.data_out   = r_data_out;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);

    // Control FSM with window accumulation and x-then-y-then-channel walk
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state    <= S_IDLE;
            r_chnls    <= '0;
            r_oh       <= '0;
            r_ow       <= '0;
            r_c        <= '0;
            r_py       <= '0;
            r_px       <= '0;
            r_acc      <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_chnls <= bus.num_chnls;
                        r_oh    <= w_oh_in;
                        r_ow    <= w_ow_in;
                        r_c     <= '0;
                        r_py    <= '0;
                        r_px    <= '0;
                        r_state <= w_empty ? S_DONE : S_RD0;
                    end
                end
                S_RD0: r_state <= S_RD1;
                S_RD1: begin
                    r_acc   <= w_din;
                    r_state <= S_RD2;
                end
                S_RD2: begin
                    r_acc   <= w_max;
                    r_state <= S_RD3;
                end
                S_RD3: begin
                    r_acc   <= w_max;
                    r_state <= S_LAST;
                end
                S_LAST: begin
                    r_data_out <= w_max;
                    r_state    <= S_WR;
                end
                S_WR: begin
                    if (w_px_last) begin
                        r_px <= '0;
                        if (w_py_last) begin
                            r_py <= '0;
                            r_c  <= r_c + 4'd1;
                        end else begin
                            r_py <= r_py + 4'd1;
                        end
                    end else begin
                        r_px <= r_px + 4'd1;
                    end
                    r_state <= (w_px_last && w_py_last && w_c_last) ? S_DONE : S_RD0;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// tb/tb_pool_ctrl.sv - self-checking bench for pool_ctrl against a window-max model
module tb_pool_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 18;
    localparam int IFB = 131072;
    localparam int OFB = 196608;

    logic clk   = 1'b0;
    logic srstn = 1'b0;
    always #5 clk = ~clk;

    pool_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pool_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .IFMAP_BASE(18'd131072),
        .OFMAP_BASE(18'd196608)
    ) dut (
        .clk  (clk),
        .srstn(srstn),
        .bus  (bus)
    );

    // DRAM: read data appears the cycle after the address
    logic [DW-1:0] dram [0:262143];
    logic [DW-1:0] rd_q;
    always @(posedge clk) if (bus.dram_en_rd) rd_q <= dram[bus.addr_in];
    assign bus.data_in = rd_q;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state for the current run
    int exp_rd[$];
    int exp_wa[$];
    int exp_wd[$];
    int obs_wa[$];
    int obs_wd[$];
    int run_base = 0;
    int run_lo   = 0;
    int run_hi   = -1;
    int obs_done = -1;
    int busy_cnt = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected read/write streams and timing from the pooling rules
    task automatic plan(input int nc, input int h, input int w);
        int oh, ow, n, a, v, m;
        oh = h / 2;
        ow = w / 2;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        obs_wa.delete(); obs_wd.delete();
        for (int ch = 0; ch < nc; ch++)
            for (int py = 0; py < oh; py++)
                for (int px = 0; px < ow; px++) begin
                    m = 0;
                    for (int k = 0; k < 4; k++) begin
                        a = IFB + ch * 1024 + (2 * py + k / 2) * 32 + 2 * px + k % 2;
                        exp_rd.push_back(a);
                        v = $signed(dram[a]);
                        if (k == 0 || v > m) m = v;
                    end
                    exp_wa.push_back(OFB + ch * 1024 + py * 32 + px);
                    exp_wd.push_back(m);
                end
        n        = nc * oh * ow;
        run_base = cyc;
        run_lo   = cyc + 1;
        run_hi   = cyc + 1 + 6 * n;
        obs_done = -1;
        busy_cnt = 0;
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (srstn) begin
            chk("busy", bus.busy, (cyc >= run_lo && cyc <= run_hi));
            chk("done", bus.done, (cyc == run_hi));
            chk("rd_wr_excl", bus.dram_en_rd & bus.dram_en_wr, 0);
            if (bus.busy) busy_cnt++;
            if (bus.done) obs_done = cyc;
            if (bus.dram_en_rd) begin
                if (exp_rd.size() == 0) chk("rd_unexpected_addr", bus.addr_in, -1);
                else chk("rd_addr", bus.addr_in, exp_rd.pop_front());
            end else begin
                chk("addr_in_idle", bus.addr_in, 0);
            end
            if (bus.dram_en_wr) begin
                obs_wa.push_back(bus.addr_out);
                obs_wd.push_back($signed(bus.data_out));
                if (exp_wa.size() == 0) chk("wr_unexpected_addr", bus.addr_out, -1);
                else begin
                    chk("wr_addr", bus.addr_out, exp_wa.pop_front());
                    chk("wr_data", $signed(bus.data_out), exp_wd.pop_front());
                end
            end else begin
                chk("addr_out_idle", bus.addr_out, 0);
            end
        end
    end

    task automatic start(input int nc, input int h, input int w);
        @(negedge clk);
        bus.num_chnls  = 5'(nc);
        bus.map_height = 6'(h);
        bus.map_width  = 6'(w);
        bus.enable     = 1'b1;
        plan(nc, h, w);
        @(posedge clk);
        #1 bus.enable = 1'b0;
    endtask

    task automatic finish_run(input int extra);
        int guard;
        guard = 0;
        while (cyc <= run_hi + extra && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("run_timeout", guard < 2000, 1);
        chk("done_seen", obs_done, run_hi);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wa.size(), 0);
    endtask

    task automatic fill_rand();
        for (int a = IFB; a < IFB + 16384; a++) dram[a] = $urandom;
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.num_chnls  = '0;
        bus.map_height = '0;
        bus.map_width  = '0;
        fill_rand();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {bus.busy, bus.done, bus.dram_en_rd, bus.dram_en_wr}, 0);
        chk("reset_addr", {bus.addr_in, bus.addr_out}, 0);
        chk("reset_data_out", bus.data_out, 0);
        @(negedge clk) srstn = 1'b1;

        // Single window, mixed signs
        dram[131072] = 5; dram[131073] = -3; dram[131104] = 9; dram[131105] = 2;
        start(1, 2, 2);
        finish_run(2);
        chk("t1_nwr", obs_wa.size(), 1);
        chk("t1_addr", obs_wa[0], 196608);
        chk("t1_data", obs_wd[0], 9);
        chk("t1_done_lat", obs_done - run_base, 7);
        chk("t1_busy_cycles", busy_cnt, 7);

        // All negative: signed compare must pick -2
        dram[131072] = -8; dram[131073] = -2; dram[131104] = -5; dram[131105] = -7;
        start(1, 2, 2);
        finish_run(2);
        chk("t2_data", obs_wd[0], -2);

        // Two channels, odd width: column 4 never read
        fill_rand();
        start(2, 4, 5);
        finish_run(2);
        chk("t3_nwr", obs_wa.size(), 8);
        chk("t3_a0", obs_wa[0], 196608);
        chk("t3_a1", obs_wa[1], 196609);
        chk("t3_a2", obs_wa[2], 196640);
        chk("t3_a3", obs_wa[3], 196641);
        chk("t3_a4", obs_wa[4], 197632);
        chk("t3_a7", obs_wa[7], 197665);
        chk("t3_done_lat", obs_done - run_base, 49);

        // Degenerate geometry: no DRAM traffic, done next cycle
        start(0, 4, 4);
        finish_run(3);
        chk("t4_done_lat", obs_done - run_base, 1);
        start(2, 1, 6);
        finish_run(3);
        chk("t5_done_lat", obs_done - run_base, 1);
        chk("t5_nwr", obs_wa.size(), 0);

        // Odd sizes, three channels
        fill_rand();
        start(3, 7, 6);
        finish_run(2);
        chk("t6_nwr", obs_wa.size(), 27);

        // Reset during RD2 of the second element
        fill_rand();
        start(1, 2, 4);
        while (cyc < run_base + 9) @(negedge clk);
        #2 srstn = 1'b0;
        #1;
        chk("rst_mid_ctl", {bus.busy, bus.done, bus.dram_en_rd, bus.dram_en_wr}, 0);
        chk("rst_mid_addr", {bus.addr_in, bus.addr_out}, 0);
        chk("rst_mid_data_out", bus.data_out, 0);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        run_lo = 0;
        run_hi = -1;
        chk("rst_mid_nwr", obs_wa.size(), 1);
        chk("rst_mid_a0", obs_wa[0], 196608);
        repeat (3) @(negedge clk);
        #1 srstn = 1'b1;
        repeat (3) @(negedge clk);
        start(2, 6, 4);
        finish_run(2);
        chk("rst_rerun_nwr", obs_wa.size(), 12);
        chk("rst_rerun_a0", obs_wa[0], 196608);

        // Port changes mid-run and enable held into DONE are ignored
        start(2, 4, 4);
        repeat (10) @(negedge clk);
        bus.enable     = 1'b1;
        bus.num_chnls  = 5'd5;
        bus.map_width  = 6'd20;
        bus.map_height = 6'd2;
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        while (cyc < run_hi && cyc < run_base + 200) @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        finish_run(4);
        chk("t8_nwr", obs_wa.size(), 8);
        chk("t8_a7", obs_wa[7], 197665);
        chk("t8_done_lat", obs_done - run_base, 49);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
2x2/stride-2 signed max-pooling controller and datapath for the subsampling layer that follows convolution.
- Reads the convolution output maps from DRAM and computes the max of each 2x2 window.
- Writes the pooled maps back to DRAM in the same chnl/y/x address layout used by the convolution stage.
- Started by the layer sequencer with the same enable/done protocol as the convolution controller; shares the DRAM port when that controller is idle.

Parameters:
DATA_WIDTH, 32, width of one map element (signed two's complement)
ADDR_WIDTH, 18, DRAM word address width
IFMAP_BASE, 18'd131072, base address of the maps to pool (conv ofmap region)
OFMAP_BASE, 18'd196608, base address of the pooled output maps

Ports:
clk  input  1  clock, all logic on rising edge
srstn  input  1  reset, asynchronous, active-low
enable  input  1  start request, sampled only in IDLE
num_chnls  input  5  number of channels (0..16), latched at start
map_height  input  6  input map height (0..32), latched at start
map_width  input  6  input map width (0..32), latched at start
data_in  input  DATA_WIDTH  DRAM read data, valid the cycle after the address is issued
addr_in  output  ADDR_WIDTH  DRAM read address
addr_out  output  ADDR_WIDTH  DRAM write address
data_out  output  DATA_WIDTH  DRAM write data (registered)
dram_en_rd  output  1  read enable
dram_en_wr  output  1  write enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, srstn=0): state=IDLE, all counters, latched parameters, accumulator and data_out are 0. All outputs are 0 immediately. A reset mid-run aborts the run with no further DRAM accesses.
- Start: in IDLE with enable=1, latch num_chnls, map_height and map_width, clear the counters, and go to RD0. Otherwise stay in IDLE. Enable is ignored outside IDLE. Port changes after latching have no effect on the current run.
- Output dims: OH=map_height>>1, OW=map_width>>1 (floor). An odd last row or column is never read. If num_chnls==0, OH==0 or OW==0, go IDLE->DONE with no DRAM access.
- Counters: c (4b) channel, py (4b) pooled row, px (4b) pooled column. Window origin is x=2*px, y=2*py.
- Read address: IFMAP_BASE + {4'd0, c, y+dy, x+dx}, with the y and x fields 5 bits each.
- Write address: OFMAP_BASE + {4'd0, c, 1'b0, py, 1'b0, px}.
- States: IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE. Each output element takes exactly 6 cycles (RD0..WR).
  - RD0: issue read (dx,dy)=(0,0).
  - RD1: issue read (1,0); acc<=data_in.
  - RD2: issue read (0,1); acc<=max(acc,data_in).
  - RD3: issue read (1,1); acc<=max(acc,data_in).
  - LAST: no read; data_out<=max(acc,data_in).
  - WR: dram_en_wr=1, addr_out=write address, data_out held. Then advance: px+1; at px==OW-1, px=0 and py+1; at py==OH-1, py=0 and c+1. After the last element (c==num_chnls-1, py==OH-1, px==OW-1), go to DONE; else go to RD0.
  - DONE: done=1 for one cycle, then IDLE.
- max is a signed DATA_WIDTH compare. Ties keep either value (equal anyway).
- dram_en_rd=1 only in RD0..RD3, and addr_in=0 otherwise. dram_en_wr=1 only in WR, and addr_out=0 otherwise. Read and write are never active in the same cycle.
- Latency: with N=num_chnls*OH*OW>0, done is high in the cycle 1+6N cycles after the enable-sampling edge. With N=0, done is high the cycle after that edge.
- Write order: x fastest, then y, then channel.

Test Plan:
- C=1, H=W=2, DRAM[131072,131073,131104,131105]={5,-3,9,2}, enable pulse -> one write: addr 196608, data 9; done 7 cycles after enable; busy high 7 cycles.
- Same geometry, data {-8,-2,-5,-7} -> write data -2 (signed compare, not unsigned).
- C=2, H=4, W=5 -> 8 writes in order 196608, 196609, 196640, 196641, then 197632, 197633, 197664, 197665. Column x=4 is never read. Done at cycle 49.
- num_chnls=0 (and separately H=1) -> done the cycle after enable; dram_en_rd/dram_en_wr never asserted.
- Pull srstn low during RD2 of the second element -> all outputs 0 asynchronously; no write for that element; after release, a new enable with different dims runs correctly from c=py=px=0.
- Toggle enable and change num_chnls/map_width mid-run -> ignored; write count and addresses match the latched values; enable with state in DONE is ignored.
